aes_core_scheduler: RTL and testbench
=====================================

# aes_core_scheduler

Time-shared controller for the single `aes_128` core used by the RT round stages. It accepts encryption jobs from `N_REQ` round-stage requesters over a valid/ready handshake and arbitrates between them round-robin. For each granted job it drives the core's start/reset, keyless mode, data and key inputs. It then waits the core's fixed latency, captures the result and returns it to the owning requester with a one-cycle response strobe. It replaces the per-stage private AES instances and their hand-counted "empty" wait states.

## Interface

- `N_REQ`, default 4: number of requesters (RT stages).
- `AES_W`, default 128: block and key width.
- `AES_LAT`, default 5: cycles from `aes_rst` deassertion to valid `aes_out`.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset rst, synchronous, active-high.
- `req_valid` in N_REQ: per-requester job request. Held until accepted.
- `req_keyless` in N_REQ: per-requester mode. 1 = keyless permutation, 0 = keyed.
- `req_data` in N_REQ*AES_W: per-requester plaintext. Slot i occupies bits [i*AES_W +: AES_W].
- `req_key` in N_REQ*AES_W: per-requester key, same packing as `req_data`.
- `req_ready` out N_REQ: one-hot acceptance pulse.
- `rsp_valid` out N_REQ: one-hot result strobe, one cycle.
- `rsp_data` out AES_W: result. Valid while any `rsp_valid` bit is set, held otherwise.
- `aes_rst` out 1: core load/restart, active-high.
- `aes_keyless` out 1: core mode.
- `aes_in` out AES_W: core data input.
- `aes_key` out AES_W: core key input.
- `aes_out` in AES_W: core result.

## Operation

The scheduler is a four-state FSM: IDLE, LOAD, RUN, DONE.

- **IDLE**
  - If any `req_valid` bit is set, a round-robin pick selects requester g, searching from `last+1` modulo N_REQ.
  - In the same cycle: `req_ready[g]`=1 (combinational), latch g, `req_keyless[g]`, `req_data[g]` and `req_key[g]` into the job registers, and go to LOAD.
  - If no request is pending, stay in IDLE.
- **LOAD**
  - `aes_rst`=1 for exactly one cycle.
  - `aes_in`, `aes_key` and `aes_keyless` are driven from the job registers.
  - Load `cnt`=AES_LAT-1 and go to RUN.
- **RUN**
  - `aes_rst`=0. The core inputs stay at the job registers.
  - Decrement `cnt`. When `cnt`==0, capture `aes_out` into `rsp_data` and go to DONE.
- **DONE**
  - `rsp_valid[g]`=1 for one cycle.
  - Update `last` to g and go to IDLE.

Arbitration and handshake rules:
- The job registers remain stable from LOAD through DONE. Requester inputs are ignored after acceptance.
- A requester may drop `req_valid` before acceptance without effect. No job is ever recorded without `req_ready`.
- `req_ready` is never asserted outside IDLE and is at most one-hot.
- Round-robin is fair: with all requesters continuously valid, the grant order is 0,1,2,3,0,...
- The next grant may occur only in the IDLE cycle after DONE. There is no overlap of jobs on the core.

Reset values:
- State=IDLE, `last`=N_REQ-1 (requester 0 wins first), `cnt`=0.
- Job registers 0, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0.
- `aes_rst`=0, `aes_keyless`=0, `aes_in`=0, `aes_key`=0.

Reset mid-job aborts the job. No `rsp_valid` is issued for it, and the requester must re-request.

## Timing

Acceptance in cycle T gives:
- LOAD at T+1 (`aes_rst` high).
- RUN from T+2 to T+1+AES_LAT.
- DONE, with the `rsp_valid` pulse, at T+2+AES_LAT.

Throughput and latency:
- Earliest next acceptance is T+3+AES_LAT, so the throughput is one job per AES_LAT+3 cycles.
- Request-to-response latency is AES_LAT+2 cycles when the request is granted in its first cycle.
- Worst-case wait for a continuously valid requester is (N_REQ-1)*(AES_LAT+3) cycles before its acceptance.

Boundary behaviour:
- `rsp_data` changes only on the RUN-to-DONE transition.
- `req_valid` arriving during LOAD, RUN or DONE is served at the next IDLE.

## Structure

- Package `aes_sched_pkg` holds:
  - `AES_W`
  - default `AES_LAT`
  - the state enum `sched_state_t` (IDLE/LOAD/RUN/DONE)
  - the `RT_KEYLESS`/`RT_KEYED` mode constants shared with the RT stages.
- One sub-module, `rr_arbiter`, is natural. It is parameterised by N, takes a request vector and `last`, and returns a one-hot grant plus a grant index.
- The `aes_128` core itself is instantiated at the level above, not inside this block.

## Test plan

1. **Single job.** Requester 2 is valid with keyless=1, data=`0x00112233445566778899aabbccddeeff`, accepted at T.
   - `aes_rst` is high only at T+1.
   - `rsp_valid`=`4'b0100` at T+7 (AES_LAT=5).
   - `rsp_data` equals the reference-model output.
2. **Round-robin.** All four requesters are held valid.
   - Grants occur in order 0,1,2,3,0 at T, T+8, T+16, T+24, T+32.
   - Each `rsp_valid` matches its grant index.
3. **Input isolation.** Change `req_data[0]` and `req_key[0]` the cycle after acceptance.
   - `aes_in`/`aes_key` keep the accepted values.
   - The result matches the accepted operands.
4. **Keyed job.** Keyless=0 and key=`0x2b7e151628aed2a6abf7158809cf4f3c`.
   - `aes_keyless`=0 throughout.
   - The output matches the AES-128 vector.
5. **Mid-job reset.** Assert `rst` at T+4.
   - All outputs are 0 the next cycle and no `rsp_valid` is issued.
   - After release, the pending requester 0 is granted first.
6. **Request withdrawal.** Requester 1 pulses `req_valid` for one cycle during RUN and drops it.
   - No grant or response is ever issued to requester 1.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the time-shared AES core scheduler.
// Mode encodings are shared with the RT round stages.
package aes_sched_pkg;

  localparam int unsigned AES_W           = 128;
  localparam int unsigned AES_LAT_DEFAULT = 5;

  localparam logic RT_KEYLESS = 1'b1;
  localparam logic RT_KEYED   = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_core_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after 'last', wrapping
// around to the lowest index when nothing above 'last' is requesting.
module rr_arbiter
  import aes_sched_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             grant_any_c
);

  logic [N-1:0] hi_c;
  logic [N-1:0] sel_c;

  always_comb begin
    hi_c        = '0;
    sel_c       = '0;
    grant_c     = '0;
    grant_idx_c = '0;
    grant_any_c = |req;

    // Requesters strictly above 'last' take priority over the wrapped set.
    for (int i = 0; i < int'(N); i++) begin
      hi_c[i] = req[i] && (i > int'(last));
    end
    sel_c = (|hi_c) ? hi_c : req;

    // Descending scan so the lowest selected index is the one that sticks.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (sel_c[i]) begin
        grant_c     = '0;
        grant_c[i]  = 1'b1;
        grant_idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/aes_core_scheduler.sv
// Time-shares one aes_128 core among N_REQ RT round stages: round-robin job
// acceptance, core load/run sequencing and per-requester result strobes.
module aes_core_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned AES_W   = aes_sched_pkg::AES_W,
  parameter int unsigned AES_LAT = AES_LAT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_keyless,
  input  logic [N_REQ*AES_W-1:0] req_data,
  input  logic [N_REQ*AES_W-1:0] req_key,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [AES_W-1:0]       rsp_data,
  output logic                   aes_rst,
  output logic                   aes_keyless,
  output logic [AES_W-1:0]       aes_in,
  output logic [AES_W-1:0]       aes_key,
  input  logic [AES_W-1:0]       aes_out
);

  localparam int unsigned IDX_W = idx_w(N_REQ);
  localparam int unsigned CNT_W = (AES_LAT > 1) ? $clog2(AES_LAT) : 1;

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] job_idx_q, job_idx_d;
  logic             job_keyless_q, job_keyless_d;
  logic [AES_W-1:0] job_data_q, job_data_d;
  logic [AES_W-1:0] job_key_q, job_key_d;
  logic [AES_W-1:0] rsp_data_d;
  logic [N_REQ-1:0] rsp_valid_d;
  logic             aes_rst_d;

  logic [N_REQ-1:0] gnt_oh_c;
  logic [IDX_W-1:0] gnt_idx_c;
  logic             gnt_any_c;
  logic [AES_W-1:0] sel_data_c;
  logic [AES_W-1:0] sel_key_c;
  logic             sel_keyless_c;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req         (req_valid),
    .last        (last_q),
    .grant_c     (gnt_oh_c),
    .grant_idx_c (gnt_idx_c),
    .grant_any_c (gnt_any_c)
  );

  // One-hot OR-mux of the granted requester's operands.
  always_comb begin
    sel_data_c    = '0;
    sel_key_c     = '0;
    sel_keyless_c = |(req_keyless & gnt_oh_c);
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt_oh_c[i]) begin
        sel_data_c = sel_data_c | req_data[i*AES_W +: AES_W];
        sel_key_c  = sel_key_c  | req_key[i*AES_W +: AES_W];
      end
    end
  end

  // Next-state and registered-output logic; req_ready is the only combinational output.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    job_idx_d     = job_idx_q;
    job_keyless_d = job_keyless_q;
    job_data_d    = job_data_q;
    job_key_d     = job_key_q;
    rsp_data_d    = rsp_data;
    rsp_valid_d   = '0;
    aes_rst_d     = 1'b0;
    req_ready     = '0;

    case (state_q)
      IDLE: begin
        // Acceptance is blocked while reset is asserted so nothing is recorded.
        if (gnt_any_c && !rst) begin
          req_ready     = gnt_oh_c;
          job_idx_d     = gnt_idx_c;
          job_keyless_d = sel_keyless_c ? RT_KEYLESS : RT_KEYED;
          job_data_d    = sel_data_c;
          job_key_d     = sel_key_c;
          aes_rst_d     = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = CNT_W'(AES_LAT - 1);
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == '0) begin
          rsp_data_d  = aes_out;
          rsp_valid_d = N_REQ'(1) << job_idx_q;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        last_d  = job_idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_q        <= IDX_W'(N_REQ - 1);
      job_idx_q     <= '0;
      job_keyless_q <= RT_KEYED;
      job_data_q    <= '0;
      job_key_q     <= '0;
      rsp_data      <= '0;
      rsp_valid     <= '0;
      aes_rst       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      job_idx_q     <= job_idx_d;
      job_keyless_q <= job_keyless_d;
      job_data_q    <= job_data_d;
      job_key_q     <= job_key_d;
      rsp_data      <= rsp_data_d;
      rsp_valid     <= rsp_valid_d;
      aes_rst       <= aes_rst_d;
    end
  end

  // Core operands come straight from the job registers, stable LOAD..DONE.
  assign aes_in      = job_data_q;
  assign aes_key     = job_key_q;
  assign aes_keyless = job_keyless_q;

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler with a fixed-latency stand-in core.
// Each task drives at the falling edge and checks 1 ns later.
module tb_aes_core_scheduler;

  localparam int N   = 4;
  localparam int W   = 128;
  localparam int LAT = 5;

  localparam logic [W-1:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [W-1:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [W-1:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_keyless = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N*W-1:0] req_key = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           aes_rst;
  logic           aes_keyless;
  logic [W-1:0]   aes_in;
  logic [W-1:0]   aes_key;
  logic [W-1:0]   aes_out;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int sc = LAT;

  aes_core_scheduler #(.N_REQ(N), .AES_W(W), .AES_LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_keyless (req_keyless),
    .req_data    (req_data),
    .req_key     (req_key),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .aes_rst     (aes_rst),
    .aes_keyless (aes_keyless),
    .aes_in      (aes_in),
    .aes_key     (aes_key),
    .aes_out     (aes_out)
  );

  always #5 clk = ~clk;

  // Stand-in core: keyless inverts, keyed XORs, except the FIPS-197 vector.
  function automatic logic [W-1:0] core_model(input logic [W-1:0] din,
                                               input logic [W-1:0] key,
                                               input logic kl);
    if (kl) return ~din;
    if (key == FIPS_KEY && din == FIPS_PT) return FIPS_CT;
    return din ^ key;
  endfunction

  // Result only valid in the LAT-th cycle after aes_rst falls.
  always @(posedge clk) begin
    if (aes_rst) sc <= 0;
    else if (sc < LAT) sc <= sc + 1;
  end
  assign aes_out = (sc >= LAT - 1) ? core_model(aes_in, aes_key, aes_keyless)
                                   : 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'hf;
    req_keyless = 4'hf;
    req_data = {16{32'hdeadbeef}};
    req_key = {16{32'h12345678}};
    @(negedge clk);
    @(negedge clk);
    #1;
    total_cnt++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b expected 0000", req_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); else pass_cnt++;
    total_cnt++; if (aes_rst !== 1'b0) $display("FAIL reset_aes_rst: got %b expected 0", aes_rst); else pass_cnt++;
    total_cnt++; if (aes_keyless !== 1'b0) $display("FAIL reset_aes_keyless: got %b expected 0", aes_keyless); else pass_cnt++;
    total_cnt++; if (aes_in !== '0) $display("FAIL reset_aes_in: got %h expected 0", aes_in); else pass_cnt++;
    total_cnt++; if (aes_key !== '0) $display("FAIL reset_aes_key: got %h expected 0", aes_key); else pass_cnt++;
    req_valid = '0;
    req_keyless = '0;
    req_data = '0;
    req_key = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_job;
    logic [N-1:0] exp_rdy, exp_rsp;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 4'b0100;
        req_keyless = 4'b0100;
        req_data[2*W +: W] = 128'h00112233445566778899aabbccddeeff;
      end
      if (k == 1) req_valid = '0;
      #1;
      exp_rdy = (k == 0) ? 4'b0100 : 4'b0000;
      exp_rsp = (k == 7) ? 4'b0100 : 4'b0000;
      total_cnt++; if (req_ready !== exp_rdy) $display("FAIL single_ready k=%0d: got %b expected %b", k, req_ready, exp_rdy); else pass_cnt++;
      total_cnt++; if (aes_rst !== (k == 1)) $display("FAIL single_aes_rst k=%0d: got %b expected %b", k, aes_rst, (k == 1)); else pass_cnt++;
      total_cnt++; if (rsp_valid !== exp_rsp) $display("FAIL single_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, exp_rsp); else pass_cnt++;
      if (k >= 1 && k <= 7) begin
        total_cnt++; if (aes_keyless !== 1'b1) $display("FAIL single_keyless k=%0d: got %b expected 1", k, aes_keyless); else pass_cnt++;
        total_cnt++; if (aes_in !== 128'h00112233445566778899aabbccddeeff) $display("FAIL single_aes_in k=%0d: got %h expected 00112233445566778899aabbccddeeff", k, aes_in); else pass_cnt++;
      end
      if (k >= 7) begin
        total_cnt++; if (rsp_data !== 128'hffeeddccbbaa99887766554433221100) $display("FAIL single_rsp_data k=%0d: got %h expected ffeeddccbbaa99887766554433221100", k, rsp_data); else pass_cnt++;
      end
    end
    req_keyless = '0;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_rdy, exp_rsp;
    logic [W-1:0] exp_data;
    int idx;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = {4{32'ha0a00000 + 32'(i)}};
      req_key[i*W +: W]  = {4{32'h00005a5a + 32'(i << 16)}};
    end
    req_keyless = '0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      req_valid = (k < 40) ? 4'b1111 : 4'b0000;
      #1;
      idx = (k / 8) % 4;
      exp_rdy = (k % 8 == 0 && k <= 32) ? 4'(1 << idx) : 4'b0000;
      exp_rsp = (k % 8 == 7) ? 4'(1 << idx) : 4'b0000;
      total_cnt++; if (req_ready !== exp_rdy) $display("FAIL rr_ready k=%0d: got %b expected %b", k, req_ready, exp_rdy); else pass_cnt++;
      total_cnt++; if (rsp_valid !== exp_rsp) $display("FAIL rr_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, exp_rsp); else pass_cnt++;
      if (k % 8 == 7) begin
        exp_data = req_data[idx*W +: W] ^ req_key[idx*W +: W];
        total_cnt++; if (rsp_data !== exp_data) $display("FAIL rr_rsp_data k=%0d: got %h expected %h", k, rsp_data, exp_data); else pass_cnt++;
      end
    end
  endtask

  task automatic test_input_isolation;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 4'b0001;
        req_keyless = 4'b0000;
        req_data[0 +: W] = 128'h0123456789abcdeffedcba9876543210;
        req_key[0 +: W]  = 128'hffffffffffffffff0000000000000000;
      end
      if (k == 1) begin
        req_valid = '0;
        req_data[0 +: W] = 128'h55555555555555555555555555555555;
        req_key[0 +: W]  = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
      end
      #1;
      if (k >= 1 && k <= 7) begin
        total_cnt++; if (aes_in !== 128'h0123456789abcdeffedcba9876543210) $display("FAIL iso_aes_in k=%0d: got %h expected 0123456789abcdeffedcba9876543210", k, aes_in); else pass_cnt++;
        total_cnt++; if (aes_key !== 128'hffffffffffffffff0000000000000000) $display("FAIL iso_aes_key k=%0d: got %h expected ffffffffffffffff0000000000000000", k, aes_key); else pass_cnt++;
      end
      if (k >= 1 && k <= 6) begin
        total_cnt++; if (rsp_data !== '0) $display("FAIL iso_rsp_hold k=%0d: got %h expected 0", k, rsp_data); else pass_cnt++;
      end
      if (k == 7) begin
        total_cnt++; if (rsp_valid !== 4'b0001) $display("FAIL iso_rsp_valid: got %b expected 0001", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_data !== 128'hfedcba9876543210fedcba9876543210) $display("FAIL iso_rsp_data: got %h expected fedcba9876543210fedcba9876543210", rsp_data); else pass_cnt++;
      end
    end
  endtask

  task automatic test_keyed;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 4'b1000;
        req_keyless = 4'b0000;
        req_data[3*W +: W] = FIPS_PT;
        req_key[3*W +: W]  = FIPS_KEY;
      end
      if (k == 1) req_valid = '0;
      #1;
      if (k == 0) begin
        total_cnt++; if (req_ready !== 4'b1000) $display("FAIL keyed_ready: got %b expected 1000", req_ready); else pass_cnt++;
      end
      if (k >= 1 && k <= 7) begin
        total_cnt++; if (aes_keyless !== 1'b0) $display("FAIL keyed_keyless k=%0d: got %b expected 0", k, aes_keyless); else pass_cnt++;
        total_cnt++; if (aes_key !== FIPS_KEY) $display("FAIL keyed_aes_key k=%0d: got %h expected %h", k, aes_key, FIPS_KEY); else pass_cnt++;
      end
      if (k == 7) begin
        total_cnt++; if (rsp_valid !== 4'b1000) $display("FAIL keyed_rsp_valid: got %b expected 1000", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_data !== FIPS_CT) $display("FAIL keyed_rsp_data: got %h expected %h", rsp_data, FIPS_CT); else pass_cnt++;
      end
    end
  endtask

  task automatic test_mid_job_reset;
    logic [N-1:0] exp_rsp;
    // Complete a job on requester 1 so the pre-reset pointer differs from the reset one.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 4'b0010;
        req_data[1*W +: W] = 128'h0;
        req_key[1*W +: W]  = 128'h1;
      end
      if (k == 1) req_valid = '0;
      #1;
      if (k == 7) begin
        total_cnt++; if (rsp_valid !== 4'b0010) $display("FAIL mid_pre_rsp: got %b expected 0010", rsp_valid); else pass_cnt++;
      end
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 4'b0100;
      if (k == 1) req_valid = 4'b0101;
      if (k == 4) rst = 1'b1;
      if (k == 6) rst = 1'b0;
      if (k == 7) req_valid = '0;
      #1;
      exp_rsp = (k == 13) ? 4'b0001 : 4'b0000;
      total_cnt++; if (rsp_valid !== exp_rsp) $display("FAIL mid_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, exp_rsp); else pass_cnt++;
      if (k == 0) begin
        total_cnt++; if (req_ready !== 4'b0100) $display("FAIL mid_first_grant: got %b expected 0100", req_ready); else pass_cnt++;
      end
      if (k == 5) begin
        total_cnt++; if (req_ready !== 4'b0) $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); else pass_cnt++;
        total_cnt++; if (aes_rst !== 1'b0) $display("FAIL mid_rst_aes_rst: got %b expected 0", aes_rst); else pass_cnt++;
        total_cnt++; if (aes_in !== '0) $display("FAIL mid_rst_aes_in: got %h expected 0", aes_in); else pass_cnt++;
        total_cnt++; if (aes_key !== '0) $display("FAIL mid_rst_aes_key: got %h expected 0", aes_key); else pass_cnt++;
        total_cnt++; if (rsp_data !== '0) $display("FAIL mid_rst_rsp_data: got %h expected 0", rsp_data); else pass_cnt++;
      end
      if (k == 6) begin
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL mid_regrant: got %b expected 0001", req_ready); else pass_cnt++;
      end
      if (k == 7) begin
        total_cnt++; if (aes_rst !== 1'b1) $display("FAIL mid_reload: got %b expected 1", aes_rst); else pass_cnt++;
      end
    end
  endtask

  task automatic test_withdrawal;
    logic [N-1:0] exp_rdy;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 4'b0001;
        req_data[0 +: W] = 128'h11;
        req_key[0 +: W]  = 128'h22;
      end
      if (k == 1) req_valid = '0;
      if (k == 3) req_valid = 4'b0010;
      if (k == 4) req_valid = '0;
      #1;
      exp_rdy = (k == 0) ? 4'b0001 : 4'b0000;
      total_cnt++; if (req_ready !== exp_rdy) $display("FAIL wd_ready k=%0d: got %b expected %b", k, req_ready, exp_rdy); else pass_cnt++;
      total_cnt++; if (rsp_valid[1] !== 1'b0) $display("FAIL wd_rsp1 k=%0d: got %b expected 0", k, rsp_valid[1]); else pass_cnt++;
      if (k == 7) begin
        total_cnt++; if (rsp_valid !== 4'b0001) $display("FAIL wd_rsp0: got %b expected 0001", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_data !== 128'h33) $display("FAIL wd_rsp_data: got %h expected 33", rsp_data); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_input_isolation();
    test_keyed();
    test_mid_job_reset();
    test_withdrawal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
